param_pattern_src: RTL

Parameterized stimulus source that drives a SIZE-bit data bus into a downstream consumer. The consumer takes a parameter-sized input port of the same width. On a start pulse it emits a programmed number of data beats using one of four patterns, advancing on a valid/ready handshake. It holds the last value on the bus after completion so the consumer keeps seeing a stable input.

---
 rtl/param_pattern_src.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/param_pattern_src.sv
// Pattern source: on start, emits a programmed number of beats
// (increment / walking-one / LFSR / constant) over valid/ready.
//
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous active-high reset
//   start   - begin a sequence (sampled in IDLE only)
//   mode    - pattern select, latched at start
//   beats   - beat count, latched at start
//   a_ready - consumer accepts current beat
//   a_out   - data bus, holds last value after completion
//   a_valid - a_out carries an unaccepted beat
//   busy    - sequence in progress
//   done    - one-cycle completion pulse
module param_pattern_src #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned SEED  = 4'b0001
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] beats,
  input  logic             a_ready,
  output logic [SIZE-1:0]  a_out,
  output logic             a_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [SIZE-1:0] SEED_S = SIZE'(SEED);
  localparam logic [SIZE-1:0] ONE_S  = SIZE'(1);
  // an all-zero LFSR would never leave zero
  localparam logic [SIZE-1:0] LFSR_INIT =
    (SEED_S == '0) ? ONE_S : SEED_S;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] beats_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SIZE-1:0]  out_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic [CNT_W:0]   cnt_inc;
  logic             last_beat;
  logic [SIZE-1:0]  first_d;
  logic [SIZE-1:0]  next_d;

  function automatic logic [SIZE-1:0] first_pat(
    input logic [1:0] m
  );
    logic [SIZE-1:0] v;
    unique case (m)
      2'd0:    v = '0;
      2'd1:    v = ONE_S;
      2'd2:    v = LFSR_INIT;
      default: v = SEED_S;
    endcase
    return v;
  endfunction

  function automatic logic [SIZE-1:0] next_pat(
    input logic [1:0]      m,
    input logic [SIZE-1:0] cur
  );
    logic [SIZE-1:0] v;
    unique case (m)
      2'd0:    v = cur + ONE_S;
      2'd1:    v = {cur[SIZE-2:0], cur[SIZE-1]};
      2'd2:    v = {cur[SIZE-2:0],
                    cur[SIZE-1] ^ cur[SIZE-2]};
      default: v = SEED_S;
    endcase
    return v;
  endfunction

  assign accept  = valid_q & a_ready;
  // one extra bit so beats = 2^CNT_W-1 compares cleanly
  assign cnt_inc = {1'b0, cnt_q}
                 + {{CNT_W{1'b0}}, 1'b1};
  assign last_beat = (cnt_inc == {1'b0, beats_q});
  assign first_d = first_pat(mode);
  assign next_d  = next_pat(mode_q, out_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      beats_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mode_q  <= mode;
            beats_q <= beats;
            cnt_q   <= '0;
            if (beats != '0) begin
              state_q <= S_RUN;
              out_q   <= first_d;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            cnt_q <= cnt_inc[CNT_W-1:0];
            if (last_beat) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              out_q <= next_d;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a_out   = out_q;
  assign a_valid = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
